// File: rtl/jtag_er1_pkg.sv
// Shared constants for the ER1 user data-register engine: opcodes, FSM
// encoding, status-bit placement and scan-chain length.
package jtag_er1_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Status flags sit in the opcode slot of the captured word, counted from the MSB.
    localparam int STAT_OVR_FROM_MSB  = 0;
    localparam int STAT_RDAV_FROM_MSB = 1;

    function automatic int dr_w(input int addr_w, input int data_w);
        return 2 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/jtag_er1_dr_if.sv
// Register-bus command/response channel between the ER1 engine and its consumer.
interface jtag_er1_dr_if
    import jtag_er1_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/jtag_er1_shreg.sv
// ER1 capture/shift register; jtdo1 is the register LSB itself so TDO
// never sees a combinational path from TDI.
module jtag_er1_shreg
    import jtag_er1_pkg::*;
#(
    parameter int DR_W = dr_w(ADDR_W_DEF, DATA_W_DEF)
) (
    input  logic            jtck,
    input  logic            jrstn,
    input  logic            jtdi,
    input  logic            capture,
    input  logic            shift,
    input  logic [DR_W-1:0] cap_word,
    output logic [DR_W-1:0] sr,
    output logic            jtdo1
);

    always_ff @(posedge jtck) begin
        if (!jrstn) begin
            sr <= '0;
        end else if (capture) begin
            sr <= cap_word;
        end else if (shift) begin
            sr <= {jtdi, sr[DR_W-1:1]};
        end
    end

    assign jtdo1 = sr[0];

endmodule

// File: rtl/jtag_er1_dr.sv
// ER1 user data-register engine: scanned words become single register-bus
// commands on Update-DR; read data and status return at the next Capture-DR.
module jtag_er1_dr
    import jtag_er1_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic          jtck,
    input  logic          jrstn,
    input  logic          jtdi,
    input  logic          jce1,
    input  logic          jshift,
    input  logic          jupdate,
    input  logic          jrti1,
    output logic          jtdo1,
    jtag_er1_dr_if.master bus,
    output logic          busy
);

    localparam int DR_W = dr_w(ADDR_W, DATA_W);

    state_t            state;
    logic              cmd_valid_q;
    logic              cmd_we_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;
    logic [DATA_W-1:0] rdata;
    logic              rd_avail;
    logic              ovr;
    logic              jupdate_q;

    logic [DR_W-1:0]   sr;
    logic [DR_W-1:0]   cap_word;
    logic              capture;
    logic              shift;
    logic              upd_fire;
    logic              accept_ok;
    logic [1:0]        sr_op;
    logic [ADDR_W-1:0] sr_addr;
    logic [DATA_W-1:0] sr_data;

    // RTI carries no function here; it only marks idle clocks from the host.
    logic unused_ok;
    assign unused_ok = &{1'b0, jrti1};

    assign capture = jce1 && !jshift;
    assign shift   = jce1 && jshift;

    // Capture and update never coincide on a real TAP; if forced, capture wins.
    assign upd_fire = jupdate && !jupdate_q && !capture;

    assign sr_op   = sr[DR_W-1 -: 2];
    assign sr_addr = sr[DATA_W +: ADDR_W];
    assign sr_data = sr[DATA_W-1:0];

    // A response arriving in the same cycle frees the engine for this update.
    assign accept_ok = (state == ST_IDLE) || (state == ST_WAIT && bus.rsp_valid);

    always_comb begin
        cap_word                               = '0;
        cap_word[DATA_W-1:0]                   = rdata;
        cap_word[DATA_W +: ADDR_W]             = ADDR_W'(state);
        cap_word[DR_W-1-STAT_OVR_FROM_MSB]     = ovr;
        cap_word[DR_W-1-STAT_RDAV_FROM_MSB]    = rd_avail;
    end

    jtag_er1_shreg #(
        .DR_W (DR_W)
    ) u_shreg (
        .jtck     (jtck),
        .jrstn    (jrstn),
        .jtdi     (jtdi),
        .capture  (capture),
        .shift    (shift),
        .cap_word (cap_word),
        .sr       (sr),
        .jtdo1    (jtdo1)
    );

    always_ff @(posedge jtck) begin
        if (!jrstn) begin
            state       <= ST_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rdata       <= '0;
            rd_avail    <= 1'b0;
            ovr         <= 1'b0;
            jupdate_q   <= 1'b0;
        end else begin
            jupdate_q <= jupdate;

            case (state)
                ST_CMD: begin
                    if (bus.cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state       <= cmd_we_q ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.rsp_valid) begin
                        rdata    <= bus.rsp_rdata;
                        rd_avail <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: ;
            endcase

            // Later assignments override the response/handshake updates above.
            if (upd_fire) begin
                case (sr_op)
                    OP_WRITE: begin
                        if (accept_ok) begin
                            cmd_valid_q <= 1'b1;
                            cmd_we_q    <= 1'b1;
                            cmd_addr_q  <= sr_addr;
                            cmd_wdata_q <= sr_data;
                            state       <= ST_CMD;
                        end else begin
                            ovr <= 1'b1;
                        end
                    end
                    OP_READ: begin
                        if (accept_ok) begin
                            cmd_valid_q <= 1'b1;
                            cmd_we_q    <= 1'b0;
                            cmd_addr_q  <= sr_addr;
                            rd_avail    <= 1'b0;
                            state       <= ST_CMD;
                        end else begin
                            ovr <= 1'b1;
                        end
                    end
                    OP_CLEAR: begin
                        ovr      <= 1'b0;
                        rd_avail <= 1'b0;
                    end
                    OP_NOP: ;
                    default: ;
                endcase
            end
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_we    = cmd_we_q;
    assign bus.cmd_addr  = cmd_addr_q;
    assign bus.cmd_wdata = cmd_wdata_q;
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_jtag_er1_dr.sv
// Bench for jtag_er1_dr: directed table, corner-case sequences and random
// scans, every cycle compared against a bit-queue/transaction reference model.
module tb_jtag_er1_dr;

    logic jtck = 1'b0;
    logic jrstn, jtdi, jce1, jshift, jupdate, jrti1;
    logic jtdo1, busy;

    jtag_er1_dr_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    jtag_er1_dr #(.ADDR_W(6), .DATA_W(32)) dut (
        .jtck    (jtck),
        .jrstn   (jrstn),
        .jtdi    (jtdi),
        .jce1    (jce1),
        .jshift  (jshift),
        .jupdate (jupdate),
        .jrti1   (jrti1),
        .jtdo1   (jtdo1),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 jtck = ~jtck;

    int checks = 0;
    int failures = 0;

    // Reference model: the chain is a queue of bits, TDO end at index 0.
    localparam int M_IDLE = 0, M_CMD = 1, M_WAIT = 2;
    bit          m_q[$];
    int          m_mode = M_IDLE;
    logic        m_valid = 0, m_we = 0, m_rdav = 0, m_ovr = 0, m_updq = 0;
    logic [5:0]  m_addr = 0;
    logic [31:0] m_wdata = 0, m_rdata = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [39:0] capw;
        logic [31:0] d;
        logic [5:0]  a;
        logic [1:0]  op;
        bit cap, sh, upd, free;
        if (!jrstn) begin
            m_q.delete();
            repeat (40) m_q.push_back(1'b0);
            m_mode = M_IDLE; m_valid = 0; m_we = 0; m_addr = 0; m_wdata = 0;
            m_rdata = 0; m_rdav = 0; m_ovr = 0; m_updq = 0;
            return;
        end
        for (int i = 0; i < 32; i++) d[i] = m_q[i];
        for (int i = 0; i < 6; i++)  a[i] = m_q[32+i];
        op   = {m_q[39], m_q[38]};
        capw = {m_ovr, m_rdav, 6'(m_mode), m_rdata};
        cap  = jce1 && !jshift;
        sh   = jce1 && jshift;
        upd  = jupdate && !m_updq && !cap;
        free = (m_mode == M_IDLE) || (m_mode == M_WAIT && bus.rsp_valid);
        if (m_mode == M_CMD && bus.cmd_ready) begin
            m_valid = 0;
            m_mode  = m_we ? M_IDLE : M_WAIT;
        end else if (m_mode == M_WAIT && bus.rsp_valid) begin
            m_rdata = bus.rsp_rdata; m_rdav = 1; m_mode = M_IDLE;
        end
        if (upd) begin
            if (op == 2'b01 || op == 2'b10) begin
                if (free) begin
                    m_valid = 1; m_addr = a; m_mode = M_CMD;
                    m_we = (op == 2'b01);
                    if (op == 2'b01) m_wdata = d;
                    else             m_rdav = 0;
                end else begin
                    m_ovr = 1;
                end
            end else if (op == 2'b11) begin
                m_ovr = 0; m_rdav = 0;
            end
        end
        if (cap) begin
            for (int i = 0; i < 40; i++) m_q[i] = capw[i];
        end else if (sh) begin
            m_q.delete(0);
            m_q.push_back(jtdi);
        end
        m_updq = jupdate;
    endtask

    task automatic cyc();
        model_step();
        @(posedge jtck);
        #1;
        chk("jtdo1", jtdo1, m_q[0]);
        chk("cmd_valid", bus.cmd_valid, m_valid);
        chk("cmd_we", bus.cmd_we, m_we);
        chk("cmd_addr", bus.cmd_addr, m_addr);
        chk("cmd_wdata", bus.cmd_wdata, m_wdata);
        chk("busy", busy, m_mode != M_IDLE);
    endtask

    task automatic scan(input logic [39:0] din, input bit cap, output logic [39:0] dout);
        if (cap) begin
            jce1 = 1; jshift = 0; cyc();
        end
        jce1 = 1; jshift = 1;
        for (int i = 0; i < 40; i++) begin
            dout[i] = jtdo1;
            jtdi = din[i];
            cyc();
        end
        jce1 = 0; jshift = 0; jtdi = 0;
    endtask

    task automatic update(input int hold);
        jupdate = 1;
        repeat (hold) cyc();
        jupdate = 0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  addr;
        logic [31:0] data;
        int          rdy_wait;
        int          rsp_wait;
        logic [31:0] rsp;
        logic [39:0] exp_cap;
        logic [5:0]  exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] dout;
        logic [39:0] pat;

        tbl[0] = '{2'b01, 6'h15, 32'hDEADBEEF, 2, 0, 32'h0,       40'h00_0000_0000, 6'h15, 32'hDEADBEEF};
        tbl[1] = '{2'b10, 6'h03, 32'h0,        0, 3, 32'h12345678, 40'h00_0000_0000, 6'h03, 32'hDEADBEEF};
        tbl[2] = '{2'b00, 6'h2C, 32'h0BADCAFE, 0, 0, 32'h0,       40'h40_1234_5678, 6'h00, 32'h0};
        tbl[3] = '{2'b11, 6'h00, 32'h0,        0, 0, 32'h0,       40'h40_1234_5678, 6'h00, 32'h0};
        tbl[4] = '{2'b01, 6'h3F, 32'h0,        0, 0, 32'h0,       40'h00_1234_5678, 6'h3F, 32'h0};
        tbl[5] = '{2'b00, 6'h00, 32'h0,        0, 0, 32'h0,       40'h00_1234_5678, 6'h00, 32'h0};

        m_q.delete();
        repeat (40) m_q.push_back(1'b0);
        jrstn = 0; jtdi = 1; jce1 = 1; jshift = 1; jupdate = 0; jrti1 = 0;
        bus.cmd_ready = 0; bus.rsp_valid = 0; bus.rsp_rdata = 0;

        // Reset asserted for two clocks while shifting ones in
        repeat (2) cyc();
        jrstn = 1;
        jce1 = 0; jshift = 0; jtdi = 0;
        scan(40'h0, 1, dout);
        chk("reset_cap", dout, 40'h0);

        foreach (tbl[k]) begin
            scan({tbl[k].op, tbl[k].addr, tbl[k].data}, 1, dout);
            chk("tbl_cap", dout, tbl[k].exp_cap);
            update(1);
            if (tbl[k].op == 2'b01 || tbl[k].op == 2'b10) begin
                chk("tbl_valid", bus.cmd_valid, 1'b1);
                chk("tbl_we", bus.cmd_we, tbl[k].op == 2'b01);
                chk("tbl_addr", bus.cmd_addr, tbl[k].exp_addr);
                chk("tbl_wdata", bus.cmd_wdata, tbl[k].exp_wdata);
                repeat (tbl[k].rdy_wait) cyc();
                chk("tbl_valid_held", bus.cmd_valid, 1'b1);
                bus.cmd_ready = 1; cyc(); bus.cmd_ready = 0;
                chk("tbl_valid_drop", bus.cmd_valid, 1'b0);
                if (tbl[k].op == 2'b01) chk("tbl_busy_fall", busy, 1'b0);
                else begin
                    repeat (tbl[k].rsp_wait) cyc();
                    bus.rsp_valid = 1; bus.rsp_rdata = tbl[k].rsp;
                    cyc();
                    bus.rsp_valid = 0;
                end
            end
            jrti1 = 1; repeat (2) cyc(); jrti1 = 0;
        end

        // Overrun: write while a read is outstanding
        scan({2'b10, 6'h0A, 32'h0}, 1, dout);
        update(1);
        bus.cmd_ready = 1; cyc(); bus.cmd_ready = 0;
        scan({2'b01, 6'h11, 32'h11111111}, 1, dout);
        update(1);
        chk("ovr_no_cmd", bus.cmd_valid, 1'b0);
        chk("ovr_addr_kept", bus.cmd_addr, 6'h0A);
        cyc();
        scan(40'h0, 1, dout);
        chk("ovr_set", dout[39], 1'b1);
        chk("ovr_state", dout[37:32], 6'd2);
        scan({2'b11, 6'h0, 32'h0}, 1, dout);
        update(1);
        scan(40'h0, 1, dout);
        chk("ovr_clear", dout[39:32], 8'h02);

        // Response and write update in the same cycle
        scan({2'b01, 6'h21, 32'hCAFEF00D}, 1, dout);
        bus.rsp_valid = 1; bus.rsp_rdata = 32'h55AA55AA;
        update(1);
        bus.rsp_valid = 0;
        chk("simul_valid", bus.cmd_valid, 1'b1);
        chk("simul_wdata", bus.cmd_wdata, 32'hCAFEF00D);
        bus.cmd_ready = 1; cyc(); bus.cmd_ready = 0;
        cyc();
        scan(40'h0, 1, dout);
        chk("simul_cap", dout, 40'h40_55AA_55AA);

        // Stray responses in IDLE are ignored
        bus.rsp_valid = 1; bus.rsp_rdata = 32'hFFFFFFFF;
        repeat (2) cyc();
        bus.rsp_valid = 0;
        scan(40'h0, 1, dout);
        chk("rsp_ignored", dout, 40'h40_55AA_55AA);

        // Update held two cycles decodes once
        scan({2'b01, 6'h05, 32'h5}, 1, dout);
        update(2);
        bus.cmd_ready = 1; cyc(); bus.cmd_ready = 0;
        scan(40'h0, 1, dout);
        chk("upd_hold_ovr", dout[39], 1'b0);

        // Forced capture+update: capture wins
        scan({2'b01, 6'h2A, 32'h0BADF00D}, 1, dout);
        jce1 = 1; jshift = 0; jupdate = 1;
        cyc();
        jce1 = 0; jupdate = 0;
        cyc();
        chk("collide_no_cmd", bus.cmd_valid, 1'b0);

        // Shift integrity without intermediate capture
        pat = 40'hA5_5A_0F_F0_3C;
        scan(pat, 1, dout);
        scan(40'h0, 0, dout);
        chk("shift_integrity", dout, pat);

        // Randomised traffic against the model
        for (int n = 0; n < 60; n++) begin
            logic [39:0] w;
            w = {2'($urandom_range(0, 3)), 6'($urandom), 32'($urandom)};
            bus.cmd_ready = 0; bus.rsp_valid = 0;
            scan(w, 1, dout);
            bus.cmd_ready = 1'($urandom);
            bus.rsp_valid = ($urandom % 3 == 0);
            bus.rsp_rdata = $urandom;
            update(1 + int'($urandom % 2));
            jrti1 = 1;
            repeat ($urandom_range(3, 12)) begin
                bus.cmd_ready = 1'($urandom);
                bus.rsp_valid = ($urandom % 3 == 0);
                bus.rsp_rdata = $urandom;
                cyc();
            end
            jrti1 = 0;
        end
        bus.cmd_ready = 0; bus.rsp_valid = 0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
